// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: PC, memory address, one-entry output stage with valid/ready.
// Optional IFETCH_PERF_CNT_EN adds a delivered-instruction counter (fetch_count).
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 160,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        err
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  logic [1:0]  state_reg;
  logic [31:0] pc_reg;
  logic        in_range;
  logic        load;
  logic        redirect_take;

  assign in_range      = (pc_reg[1:0] == 2'b00) && (pc_reg <= LAST_WORD);
  assign redirect_take = redirect_valid && (state_reg != S_IDLE);
  assign load          = (state_reg == S_FETCH) && !redirect_valid &&
                         (!out_valid || out_ready) && in_range;

  assign imem_addr = pc_reg;
  assign halted    = (state_reg == S_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_pc    <= 32'h0;
      err       <= 1'b0;
    end else if (redirect_take) begin
      // Flush wins over a same-cycle handshake: the held word is dropped, not delivered.
      pc_reg    <= {redirect_pc[31:2], 2'b00};
      out_valid <= 1'b0;
      state_reg <= S_FETCH;
      if (redirect_pc[1:0] != 2'b00) err <= 1'b1;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) state_reg <= S_FETCH;
        end
        S_FETCH: begin
          if (!in_range) begin
            err       <= 1'b1;
            state_reg <= S_HALT;
          end else if (load) begin
            out_instr <= imem_instr;
            out_pc    <= pc_reg;
            out_valid <= 1'b1;
            if (imem_instr == HALT_WORD) state_reg <= S_HALT;
            else                         pc_reg    <= pc_reg + 32'd4;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      fetch_count <= 32'h0;
    else if (out_valid && out_ready && !redirect_valid) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: expected (pc, instr) pairs queued by stimulus, popped by a monitor.
`timescale 1ns/1ps
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        err;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  mem [0:159];

  always #5 clk = ~clk;

  ifetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .err(err)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  // Big-endian combinational memory; out-of-range reads return zero.
  always_comb begin
    imem_instr = 32'h0;
    if (imem_addr <= 32'd156)
      imem_instr = {mem[imem_addr[7:0]], mem[imem_addr[7:0] + 8'd1],
                    mem[imem_addr[7:0] + 8'd2], mem[imem_addr[7:0] + 8'd3]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: a handshake completes at the next rising edge unless a redirect flushes it.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !redirect_valid) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_delivery: actual pc=%h instr=%h required none", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        $display("deliver pc=%h instr=%h (expect pc=%h instr=%h)", out_pc, out_instr, e[63:32], e[31:0]);
        check("deliver_pc", out_pc, e[63:32]);
        check("deliver_instr", out_instr, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 160; i++) mem[i] = 8'h00;
  endtask

  task automatic set_word(input int a, input logic [31:0] w);
    mem[a] = w[31:24]; mem[a+1] = w[23:16]; mem[a+2] = w[15:8]; mem[a+3] = w[7:0];
  endtask

  task automatic expect_word(input logic [31:0] pc, input logic [31:0] w);
    exp_q.push_back({pc, w});
  endtask

  task automatic do_reset();
    start = 0; out_ready = 0; redirect_valid = 0; redirect_pc = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    // Test 1: straight-line fetch up to a halt word
    clear_mem();
    set_word(0, 32'h2008_0001); set_word(4, 32'h2009_0002); set_word(8, 32'h0000_000C);
    do_reset();
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    expect_word(0, 32'h2008_0001); expect_word(4, 32'h2009_0002); expect_word(8, 32'h0000_000C);
    out_ready = 1;
    pulse_start();
    idle(8);
    check_drained("t1_queue_empty");
    check("t1_halted", {31'h0, halted}, 32'd1);
    check("t1_err", {31'h0, err}, 32'd0);
    check("t1_pc", imem_addr, 32'h8);
    check("t1_out_valid", {31'h0, out_valid}, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("t1_fetch_count", fetch_count, 32'd3);
`endif

    // Test 2: backpressure holds the output stage and the PC
    do_reset();
    expect_word(0, 32'h2008_0001); expect_word(4, 32'h2009_0002); expect_word(8, 32'h0000_000C);
    pulse_start();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_valid", {31'h0, out_valid}, 32'd1);
      check("t2_hold_instr", out_instr, 32'h2008_0001);
      check("t2_hold_pc", out_pc, 32'h0);
      check("t2_hold_addr", imem_addr, 32'h4);
      tick();
    end
    out_ready = 1;
    idle(6);
    check_drained("t2_queue_empty");
    check("t2_halted", {31'h0, halted}, 32'd1);

    // Test 3: redirect flush, then misaligned redirect from HALT
    clear_mem();
    set_word(0, 32'h1111_1111); set_word(4, 32'h2222_2222); set_word(8, 32'h3333_3333);
    set_word(12, 32'h4444_4444); set_word(16, 32'h5555_5555); set_word(20, 32'h0000_000C);
    do_reset();
    pulse_start();
    tick();
    check("t3_pre_valid", {31'h0, out_valid}, 32'd1);
    redirect_valid = 1; redirect_pc = 32'h10; out_ready = 1;
    tick();
    redirect_valid = 0;
    check("t3_flush_valid", {31'h0, out_valid}, 32'd0);
    check("t3_redir_addr", imem_addr, 32'h10);
    expect_word(32'h10, 32'h5555_5555); expect_word(32'h14, 32'h0000_000C);
    idle(5);
    check_drained("t3_queue_empty_a");
    check("t3_halted_a", {31'h0, halted}, 32'd1);
    check("t3_err_a", {31'h0, err}, 32'd0);
    redirect_valid = 1; redirect_pc = 32'h13;
    tick();
    redirect_valid = 0;
    check("t3_mis_addr", imem_addr, 32'h10);
    check("t3_mis_err", {31'h0, err}, 32'd1);
    check("t3_mis_halted", {31'h0, halted}, 32'd0);
    expect_word(32'h10, 32'h5555_5555); expect_word(32'h14, 32'h0000_000C);
    idle(5);
    check_drained("t3_queue_empty_b");
    check("t3_halted_b", {31'h0, halted}, 32'd1);
    check("t3_err_b", {31'h0, err}, 32'd1);
    check("t3_pc_b", imem_addr, 32'h14);
`ifdef IFETCH_PERF_CNT_EN
    check("t3_fetch_count", fetch_count, 32'd4);
`endif

    // Test 4: run off the end of memory with no halt word
    clear_mem();
    for (int a = 0; a < 160; a += 4) set_word(a, 32'h1000_0000 + 32'(a));
    do_reset();
    for (int a = 0; a < 160; a += 4) expect_word(32'(a), 32'h1000_0000 + 32'(a));
    out_ready = 1;
    pulse_start();
    idle(50);
    check_drained("t4_queue_empty");
    check("t4_err", {31'h0, err}, 32'd1);
    check("t4_halted", {31'h0, halted}, 32'd1);
    check("t4_out_valid", {31'h0, out_valid}, 32'd0);
    check("t4_last_out_pc", out_pc, 32'd156);
    check("t4_pc", imem_addr, 32'd160);

    // Test 5: asynchronous reset between edges
    do_reset();
    expect_word(0, 32'h1000_0000);
    out_ready = 1;
    pulse_start();
    tick(); tick();
    #2 reset = 1;
    #1;
    check("t5_async_valid", {31'h0, out_valid}, 32'd0);
    check("t5_async_addr", imem_addr, 32'h0);
    check("t5_async_halted", {31'h0, halted}, 32'd0);
    check_drained("t5_queue_empty");
    tick();
    reset = 0;
    idle(4);
    check("t5_idle_valid", {31'h0, out_valid}, 32'd0);
    check("t5_idle_addr", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer for the byte-addressed, big-endian instruction memory (combinational read, 4 bytes per word, image loaded at elaboration). Holds the PC, drives the memory address, and registers each fetched word plus its PC into a one-entry output stage with a valid/ready handshake to decode. Handles start, branch/jump redirect, halt-word detection and out-of-range PC faults.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_BYTES, 160, instruction memory size in bytes; legal word addresses are 0..MEM_BYTES-4
HALT_WORD, 32'h0000_000C, instruction encoding that stops fetch (syscall)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; leaves IDLE
imem_addr  out  32  byte address to instruction memory; always equals pc
imem_instr  in  32  instruction word returned combinationally for imem_addr
out_valid  out  1  output stage holds a fetched instruction
out_ready  in  1  decode accepts the output stage this cycle
out_instr  out  32  fetched instruction
out_pc  out  32  byte address of out_instr
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  new fetch address
halted  out  1  state == HALT
err  out  1  sticky fault flag

Behaviour:
- Reset (async, active-high): state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, err=0; halted=0. Reset mid-operation discards everything immediately.
- States: IDLE, FETCH, HALT.
- IDLE: no fetch; start -> FETCH at next edge.
- FETCH: load condition L = !redirect_valid && (!out_valid || out_ready) && in_range, where in_range = (pc[1:0]==0) && (pc <= MEM_BYTES-4).
  - On L: out_instr<=imem_instr, out_pc<=pc, out_valid<=1. If imem_instr==HALT_WORD: state<=HALT, pc unchanged; else pc<=pc+4 (32-bit wrap, out-of-range caught on next cycle).
  - If out_valid && out_ready && !L: out_valid<=0.
  - If !in_range && !redirect_valid: no load, err<=1, state<=HALT (pending out_valid still drains normally).
- HALT: no fetch; output stage drains via out_ready; halted=1.
- Redirect (any state except IDLE, highest priority): pc<={redirect_pc[31:2],2'b00}; out_valid<=0 (flush, even if out_ready=1 same cycle — the instruction is not counted as delivered); state<=FETCH; err unchanged. First redirected word appears in out_instr on the following edge (1-cycle redirect bubble). If redirect_pc[1:0]!=0, err<=1 as well. Redirect in IDLE is ignored.
- start in FETCH or HALT is ignored.
- Throughput: one instruction per cycle while out_ready=1; out_instr/out_pc stable while out_valid && !out_ready.
- err clears only on reset.

Optional Feature:
IFETCH_PERF_CNT_EN: defined -> adds output fetch_count [31:0], reset 0, incremented on each cycle with out_valid && out_ready && !redirect_valid (delivered instructions), wraps at 2^32. Undefined -> port and counter absent; all other behaviour identical.

Test Plan:
- Memory words 0x20080001,0x20090002,0x0000000C at 0,4,8; reset, start, out_ready=1 -> out_pc 0,4,8 on consecutive cycles, instructions match, halted=1 after third, err=0, pc stays 8.
- Same image, out_ready=0 for 3 cycles after first load -> out_instr=0x20080001/out_pc=0 held stable, imem_addr=4, no pc advance until out_ready=1.
- Redirect_pc=0x10 while out_valid=1 holding pc 4 -> out_valid=0 next cycle, then out_pc=0x10 with word at 0x10; redirect_pc=0x13 -> pc=0x10, err=1.
- No halt word in image, MEM_BYTES=160 -> last delivered out_pc=156, then err=1, halted=1, out_valid drains, no fetch at 160.
- Assert reset asynchronously mid-stream (between edges) -> out_valid=0, imem_addr=RESET_PC, state IDLE immediately; no fetch until start.
- With IFETCH_PERF_CNT_EN: 3 delivered + 1 flushed by redirect -> fetch_count=3.
